cmos_rgb565_capture: RTL

Front-end capture stage for the CMOS camera path. It samples the sensor's 8-bit parallel bus on `cmos_pclk`, pairs bytes into RGB565 pixels and discards the first frames after reset while the sensor settles. It delivers pixels with data and frame qualifiers directly to the `rgb2hsv` input (`rgb_in`, `rgb_data_valid`, `rgb_fram_valid`). It also reports pixel coordinates and sticky geometry-error flags.

---
 rtl/cmos_rgb565_capture_if.sv | 17 +
 rtl/cmos_rgb565_capture.sv | 127 ++++++++++++
 2 files changed

// File: rtl/cmos_rgb565_capture_if.sv
// Pixel bus from the CMOS capture stage to the colour-space converter.
// Master drives pixel, qualifiers and coordinates; there is no ready path.
interface cmos_rgb565_capture_if;
    logic [15:0] rgb_out;
    logic        rgb_data_valid;
    logic        rgb_fram_valid;
    logic [10:0] pix_x;
    logic [10:0] pix_y;

    modport master (
        output rgb_out, rgb_data_valid, rgb_fram_valid, pix_x, pix_y
    );

    modport slave (
        input rgb_out, rgb_data_valid, rgb_fram_valid, pix_x, pix_y
    );
endinterface

// File: rtl/cmos_rgb565_capture.sv
// Pairs sensor bytes into RGB565 pixels after a settle period; pixel out 3 edges after its first byte.
// No back-pressure: every strobe must be taken; at most one pixel per two cycles.
module cmos_rgb565_capture #(
    parameter int SKIP_FRAMES = 10,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480
) (
    input  logic                         cmos_pclk,
    input  logic                         rst_n,
    input  logic                         cmos_vsync,
    input  logic                         cmos_href,
    input  logic [7:0]                   cmos_data,
    cmos_rgb565_capture_if.master        pix_bus,
    output logic                         line_err,
    output logic                         frame_err
);
    localparam int             SW      = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES + 1) : 1;
    localparam logic [SW-1:0]  SKIP_N  = SW'(SKIP_FRAMES);
    localparam logic [10:0]    CNT_MAX = 11'd2047;
    localparam logic [10:0]    H_N     = 11'(H_ACTIVE);
    localparam logic [10:0]    V_N     = 11'(V_ACTIVE);

    typedef enum logic [1:0] {SETTLE, ACTIVE, IDLE} state_t;

    state_t       state, state_nxt;
    logic         vs_d, vs_d2, hr_d, hr_d2;
    logic [7:0]   dat_d, hi_byte;
    logic         phase;
    logic [SW-1:0] skip_cnt;
    logic [10:0]  col_cnt, row_cnt;
    logic         vs_fall, vs_rise, hr_fall, skip_inc, enter_active, pair_en;

    assign vs_fall      = vs_d2 & ~vs_d;
    assign vs_rise      = ~vs_d2 & vs_d;
    assign hr_fall      = hr_d2 & ~hr_d;
    assign enter_active = (state != ACTIVE) && (state_nxt == ACTIVE);
    // The cycle that sees vsync rise already belongs to the blanking: nothing is strobed.
    assign pair_en      = (state == ACTIVE) && !vs_rise;

    assign pix_bus.rgb_fram_valid = (state == ACTIVE);

    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d  <= 1'b0;
            vs_d2 <= 1'b0;
            hr_d  <= 1'b0;
            hr_d2 <= 1'b0;
            dat_d <= 8'd0;
        end else begin
            vs_d  <= cmos_vsync;
            vs_d2 <= vs_d;
            hr_d  <= cmos_href;
            hr_d2 <= hr_d;
            dat_d <= cmos_data;
        end
    end

    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SETTLE;
            skip_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (skip_inc) skip_cnt <= skip_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        skip_inc  = 1'b0;
        case (state)
            SETTLE: if (vs_fall) begin
                if (skip_cnt == SKIP_N) state_nxt = ACTIVE;
                else                    skip_inc  = 1'b1;
            end
            ACTIVE:  if (vs_rise) state_nxt = IDLE;
            IDLE:    if (vs_fall) state_nxt = ACTIVE;
            default: state_nxt = SETTLE;
        endcase
    end

    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            pix_bus.rgb_out        <= 16'd0;
            pix_bus.rgb_data_valid <= 1'b0;
            pix_bus.pix_x          <= 11'd0;
            pix_bus.pix_y          <= 11'd0;
            hi_byte                <= 8'd0;
            phase                  <= 1'b0;
            col_cnt                <= 11'd0;
            row_cnt                <= 11'd0;
            line_err               <= 1'b0;
            frame_err              <= 1'b0;
        end else begin
            pix_bus.rgb_data_valid <= 1'b0;
            if (enter_active) begin
                phase   <= 1'b0;
                col_cnt <= 11'd0;
                row_cnt <= 11'd0;
            end else if (pair_en) begin
                if (!hr_d) begin
                    phase <= 1'b0;
                    if (hr_fall) begin
                        col_cnt <= 11'd0;
                        if (row_cnt != CNT_MAX) row_cnt <= row_cnt + 11'd1;
                        // A dangling high byte is dropped but still marks the line bad.
                        if ((col_cnt != H_N) || phase) line_err <= 1'b1;
                    end
                end else if (!phase) begin
                    hi_byte <= dat_d;
                    phase   <= 1'b1;
                end else begin
                    pix_bus.rgb_out        <= {hi_byte, dat_d};
                    pix_bus.rgb_data_valid <= 1'b1;
                    pix_bus.pix_x          <= col_cnt;
                    pix_bus.pix_y          <= row_cnt;
                    if (col_cnt != CNT_MAX) col_cnt <= col_cnt + 11'd1;
                    phase <= 1'b0;
                end
            end else begin
                phase <= 1'b0;
            end

            if ((state == ACTIVE) && vs_rise && (row_cnt != V_N)) frame_err <= 1'b1;
        end
    end
endmodule
